pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
Pipeline sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Drives the per-stage load enables and bubble (NOP-insert) strobes of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Sequences data-memory accesses, including two-access indirect (LDI/STI) operations.
- Resolves load-use hazards and applies branch redirect/flush.
- Keeps saturating stall and flush performance counters.

Parameters:
CNT_W, 16, width of the stall_count and flush_count performance counters

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_resp  in  1  instruction fetch completes this cycle (fetch is always requested)
dmem_resp  in  1  data access completes this cycle
mem_valid  in  1  MEM stage holds a real instruction
mem_read  in  1  MEM-stage instruction reads data memory (final access)
mem_write  in  1  MEM-stage instruction writes data memory (final access)
mem_indirect  in  1  MEM-stage instruction is LDI/STI (pointer read first)
br_taken  in  1  MEM-stage control transfer resolved taken
ex_valid  in  1  EX stage holds a real instruction
ex_is_load  in  1  EX-stage instruction writes a register from memory
ex_dest  in  3  EX-stage destination register
id_src1, id_src2  in  3 each  ID-stage source registers
id_use1, id_use2  in  1 each  ID-stage instruction actually reads src1/src2
load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  register load enables
bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb  out  1 each  when loading, load a NOP (control words zero) instead of upstream data
pc_sel_target  out  1  PC mux selects branch target
dmem_read, dmem_write  out  1 each  data-memory strobes
dmem_addr_ind  out  1  MEM address mux selects latched pointer (second indirect access)
ind_latch  out  1  latch dmem read data as pointer this cycle
stall_count, flush_count  out  CNT_W each  saturating performance counters

Behaviour:
Data FSM states: D_IDLE, D_IND2.
- D_IDLE: acc = mem_valid & (mem_read|mem_write).
  - mem_indirect: dmem_read=1 regardless of final op.
  - Otherwise: dmem_read=mem_read, dmem_write=mem_write.
  - On dmem_resp & mem_indirect: ind_latch=1, go to D_IND2.
- D_IND2: dmem_addr_ind=1, dmem_read=mem_read, dmem_write=mem_write. On dmem_resp go to D_IDLE.
- final = (D_IDLE & ~mem_indirect) | D_IND2.
- dstall = acc & ~(dmem_resp & final).

Per-cycle priority, combinational outputs; unlisted loads=1, unlisted bubbles=0, pc_sel_target=0:
1. rst: all loads=1, all bubbles=1, load_pc=0, dmem strobes 0. Next state D_IDLE; counters cleared.
2. dstall: load_pc, load_if_id, load_id_ex and load_ex_mem=0; load_mem_wb=1 with bubble_mem_wb=1, so WB never repeats a write.
3. mem_valid & br_taken:
   - If imem_resp: pc_sel_target=1, load_pc=1, bubble_if_id, bubble_id_ex and bubble_ex_mem=1, flush_count++.
   - Else: freeze exactly as in rule 2 until fetch completes, so the in-flight fetch is never redirected mid-access.
4. Load-use: ex_valid & ex_is_load & ((id_use1 & id_src1==ex_dest) | (id_use2 & id_src2==ex_dest)). Effect: load_pc=0, load_if_id=0, bubble_id_ex=1.
5. ~imem_resp: load_pc=0, bubble_if_id=1.
6. Otherwise: normal advance.

Counters and boundary conditions:
- stall_count increments every non-reset cycle with load_pc=0. Both counters saturate at all-ones.
- The dstall completion cycle (dmem_resp & final) advances normally, subject to rules 3-6.
- br_taken together with acc: memory wins (rule 2).
- Reset in D_IND2: aborts to D_IDLE; dmem strobes drop the same cycle.
- mem_valid=0: no dmem strobes, state unchanged.

Test Plan:
- Reset held 2 cycles → all bubbles=1, load_pc=0, counters 0. Release with imem_resp=1 → all loads=1, bubbles=0.
- LDR in MEM, dmem_resp after 3 cycles → dmem_read=1 for 3 cycles; upstream loads=0 and bubble_mem_wb=1 for 2 cycles; advance on cycle 3; stall_count=2.
- LDI in MEM, resp on cycles 2 and 4 → ind_latch=1 on cycle 2; D_IND2 with dmem_addr_ind=1; stalls cycles 1-3; advance on cycle 4.
- ex_is_load, ex_dest=3, id_src2=3, id_use2=1 → one cycle with load_pc=load_if_id=0, bubble_id_ex=1. Same stimulus with id_use2=0 → no stall.
- br_taken with imem_resp=0 for 2 cycles then 1 → freeze 2 cycles, then pc_sel_target=1, three flush bubbles, flush_count=1.
- Force 2^CNT_W stall cycles → stall_count holds at all-ones.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for a 5-stage LC-3b pipeline.
// Produces the register load/bubble controls and the PC redirect select.
// Runs the data-memory access sequencer, including the two-access LDI/STI
// path. Also keeps saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_resp,
  input  logic             dmem_resp,
  input  logic             mem_valid,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_indirect,
  input  logic             br_taken,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_dest,
  input  logic [2:0]       id_src1,
  input  logic [2:0]       id_src2,
  input  logic             id_use1,
  input  logic             id_use2,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_if_id,
  output logic             bubble_id_ex,
  output logic             bubble_ex_mem,
  output logic             bubble_mem_wb,
  output logic             pc_sel_target,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic             dmem_addr_ind,
  output logic             ind_latch,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Data-access sequencer states: a plain access or the pointer read of an
  // indirect op happens in D_IDLE; the final indirect access in D_IND2.
  localparam logic [0:0] D_IDLE = 1'b0;
  localparam logic [0:0] D_IND2 = 1'b1;

  // Load vector bit positions
  localparam int L_PC    = 4;
  localparam int L_IF_ID = 3;
  localparam int L_ID_EX = 2;
  localparam int L_EX_MEM = 1;
  localparam int L_MEM_WB = 0;

  // Bubble vector bit positions
  localparam int B_IF_ID  = 3;
  localparam int B_ID_EX  = 2;
  localparam int B_EX_MEM = 1;
  localparam int B_MEM_WB = 0;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic             w_acc;
  logic             w_final;
  logic             w_dstall;
  logic             w_load_use;
  logic             w_br_wait;
  logic             w_redirect;
  logic             w_dmem_read;
  logic             w_dmem_write;
  logic             w_addr_ind;
  logic             w_ind_latch;
  logic [4:0]       w_load;
  logic [3:0]       w_bubble;
  logic             w_pc_sel;
  logic [1:0]       w_cnt_inc;
  logic [CNT_W-1:0] r_cnt [2];

  assign w_acc   = mem_valid & (mem_read | mem_write);
  // The access in progress is the instruction's last one unless it is the
  // pointer read of an indirect op.
  assign w_final = (r_state == D_IND2) | ((r_state == D_IDLE) & ~mem_indirect);
  assign w_dstall = w_acc & ~(dmem_resp & w_final);

  assign w_load_use = ex_valid & ex_is_load &
                      ((id_use1 & (id_src1 == ex_dest)) |
                       (id_use2 & (id_src2 == ex_dest)));

  // A taken branch waits for the in-flight fetch so it is never redirected
  // mid-access; once the fetch lands the redirect and flush happen together.
  assign w_br_wait  = mem_valid & br_taken & ~imem_resp;
  assign w_redirect = mem_valid & br_taken & imem_resp;

  // Data-memory strobes, address mux and pointer latch for the current state
  always_comb begin
    w_dmem_read  = 1'b0;
    w_dmem_write = 1'b0;
    w_addr_ind   = 1'b0;
    w_ind_latch  = 1'b0;
    w_state_next = r_state;
    if (!rst) begin
      w_addr_ind = (r_state == D_IND2);
      if (mem_valid) begin
        if (r_state == D_IDLE) begin
          if (mem_indirect) begin
            w_dmem_read = 1'b1;
          end else begin
            w_dmem_read  = mem_read;
            w_dmem_write = mem_write;
          end
        end else begin
          w_dmem_read  = mem_read;
          w_dmem_write = mem_write;
        end
      end
      if (w_acc && dmem_resp) begin
        if (r_state == D_IDLE) begin
          if (mem_indirect) begin
            w_ind_latch  = 1'b1;
            w_state_next = D_IND2;
          end
        end else begin
          w_state_next = D_IDLE;
        end
      end
    end
  end

  // Prioritised stage control: reset, memory stall, branch, load-use, fetch
  always_comb begin
    w_load   = 5'b11111;
    w_bubble = 4'b0000;
    w_pc_sel = 1'b0;
    if (rst) begin
      w_load[L_PC] = 1'b0;
      w_bubble     = 4'b1111;
    end else if (w_dstall || w_br_wait) begin
      // Freeze everything upstream of MEM/WB; WB gets a NOP so it never
      // repeats the previous instruction's write.
      w_load[L_PC]     = 1'b0;
      w_load[L_IF_ID]  = 1'b0;
      w_load[L_ID_EX]  = 1'b0;
      w_load[L_EX_MEM] = 1'b0;
      w_bubble[B_MEM_WB] = 1'b1;
    end else if (w_redirect) begin
      w_pc_sel = 1'b1;
      w_bubble[B_IF_ID]  = 1'b1;
      w_bubble[B_ID_EX]  = 1'b1;
      w_bubble[B_EX_MEM] = 1'b1;
    end else if (w_load_use) begin
      w_load[L_PC]    = 1'b0;
      w_load[L_IF_ID] = 1'b0;
      w_bubble[B_ID_EX] = 1'b1;
    end else if (!imem_resp) begin
      w_load[L_PC]      = 1'b0;
      w_bubble[B_IF_ID] = 1'b1;
    end
  end

  // Sequencer state register; reset aborts any indirect op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= D_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Counter 0 counts cycles the PC is held, counter 1 counts redirects
  assign w_cnt_inc[0] = ~rst & ~w_load[L_PC];
  assign w_cnt_inc[1] = ~rst & w_pc_sel;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      // Saturating performance counter
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt[gi] <= '0;
        end else if (w_cnt_inc[gi] && (r_cnt[gi] != CNT_MAX)) begin
          r_cnt[gi] <= r_cnt[gi] + CNT_ONE;
        end
      end
    end
  endgenerate

  assign load_pc       = w_load[L_PC];
  assign load_if_id    = w_load[L_IF_ID];
  assign load_id_ex    = w_load[L_ID_EX];
  assign load_ex_mem   = w_load[L_EX_MEM];
  assign load_mem_wb   = w_load[L_MEM_WB];
  assign bubble_if_id  = w_bubble[B_IF_ID];
  assign bubble_id_ex  = w_bubble[B_ID_EX];
  assign bubble_ex_mem = w_bubble[B_EX_MEM];
  assign bubble_mem_wb = w_bubble[B_MEM_WB];
  assign pc_sel_target = w_pc_sel;
  assign dmem_read     = w_dmem_read;
  assign dmem_write    = w_dmem_write;
  assign dmem_addr_ind = w_addr_ind;
  assign ind_latch     = w_ind_latch;
  assign stall_count   = r_cnt[0];
  assign flush_count   = r_cnt[1];

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed test-plan sequences followed by random stimulus.
// Every cycle the outputs are checked against a rule-level reference model.
module tb_pipe_ctrl;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // Output vector bit positions
  localparam int O_LPC = 13, O_LIFID = 12, O_LIDEX = 11, O_LEXMEM = 10, O_LMEMWB = 9;
  localparam int O_BIFID = 8, O_BIDEX = 7, O_BEXMEM = 6, O_BMEMWB = 5;
  localparam int O_PCSEL = 4, O_RD = 3, O_WR = 2, O_AIND = 1, O_LATCH = 0;

  typedef struct packed {
    logic       rst, imem_resp, dmem_resp, mem_valid, mem_read, mem_write;
    logic       mem_indirect, br_taken, ex_valid, ex_is_load;
    logic [2:0] ex_dest, id_src1, id_src2;
    logic       id_use1, id_use2;
  } stim_t;

  logic clk = 1'b0;
  logic rst, imem_resp, dmem_resp, mem_valid, mem_read, mem_write;
  logic mem_indirect, br_taken, ex_valid, ex_is_load;
  logic [2:0] ex_dest, id_src1, id_src2;
  logic id_use1, id_use2;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb;
  logic pc_sel_target, dmem_read, dmem_write, dmem_addr_ind, ind_latch;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_fail   = 0;
  int step_no  = 0;

  // Reference model state
  bit m_ind2  = 1'b0;
  bit m_known = 1'b0;
  int m_stall = 0;
  int m_flush = 0;
  logic [13:0] last_out;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_resp(dmem_resp),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_indirect(mem_indirect), .br_taken(br_taken), .ex_valid(ex_valid),
    .ex_is_load(ex_is_load), .ex_dest(ex_dest), .id_src1(id_src1),
    .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .bubble_if_id(bubble_if_id), .bubble_id_ex(bubble_id_ex),
    .bubble_ex_mem(bubble_ex_mem), .bubble_mem_wb(bubble_mem_wb),
    .pc_sel_target(pc_sel_target), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr_ind(dmem_addr_ind), .ind_latch(ind_latch),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  // Expected outputs from the rules: pick the first rule that applies,
  // then write out the stage controls that rule dictates.
  function automatic logic [13:0] model(input stim_t s, input bit ind2);
    logic [4:0] ld;
    logic [3:0] bb;
    logic pcsel, rd, wr, aind, latch;
    bit acc, fin, dst, lu;
    int rule;
    ld = 5'b11111; bb = 4'b0000; pcsel = 0; rd = 0; wr = 0; aind = 0; latch = 0;
    acc = s.mem_valid && (s.mem_read || s.mem_write);
    fin = ind2 || !s.mem_indirect;
    dst = acc && !(s.dmem_resp && fin);
    lu  = s.ex_valid && s.ex_is_load &&
          ((s.id_use1 && s.id_src1 == s.ex_dest) || (s.id_use2 && s.id_src2 == s.ex_dest));
    if (s.rst) rule = 1;
    else if (dst) rule = 2;
    else if (s.mem_valid && s.br_taken) rule = s.imem_resp ? 3 : 2;
    else if (lu) rule = 4;
    else if (!s.imem_resp) rule = 5;
    else rule = 6;
    case (rule)
      1: begin ld = 5'b01111; bb = 4'b1111; end
      2: begin ld = 5'b00001; bb = 4'b0001; end
      3: begin pcsel = 1; bb = 4'b1110; end
      4: begin ld = 5'b00111; bb = 4'b0100; end
      5: begin ld = 5'b01111; bb = 4'b1000; end
      default: ;
    endcase
    if (!s.rst) begin
      aind = ind2;
      if (s.mem_valid) begin
        rd = (!ind2 && s.mem_indirect) ? 1'b1 : s.mem_read;
        wr = (!ind2 && s.mem_indirect) ? 1'b0 : s.mem_write;
      end
      latch = acc && !ind2 && s.mem_indirect && s.dmem_resp;
    end
    return {ld, bb, pcsel, rd, wr, aind, latch};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, step_no, got, exp);
    end
  endtask

  // One cycle: drive inputs, compare every output with the model, then
  // advance model state across the clock edge.
  task automatic step(input stim_t s);
    logic [13:0] exp_o;
    logic [13:0] got_o;
    @(negedge clk);
    rst = s.rst; imem_resp = s.imem_resp; dmem_resp = s.dmem_resp;
    mem_valid = s.mem_valid; mem_read = s.mem_read; mem_write = s.mem_write;
    mem_indirect = s.mem_indirect; br_taken = s.br_taken; ex_valid = s.ex_valid;
    ex_is_load = s.ex_is_load; ex_dest = s.ex_dest; id_src1 = s.id_src1;
    id_src2 = s.id_src2; id_use1 = s.id_use1; id_use2 = s.id_use2;
    #1;
    exp_o = model(s, m_ind2);
    got_o = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
             bubble_if_id, bubble_id_ex, bubble_ex_mem, bubble_mem_wb,
             pc_sel_target, dmem_read, dmem_write, dmem_addr_ind, ind_latch};
    last_out = got_o;
    check("outputs", int'(got_o), int'(exp_o));
    if (m_known) begin
      check("stall_count", int'(stall_count), m_stall);
      check("flush_count", int'(flush_count), m_flush);
    end
    @(posedge clk);
    step_no++;
    if (s.rst) begin
      m_ind2 = 0; m_stall = 0; m_flush = 0; m_known = 1;
    end else begin
      if (!exp_o[O_LPC] && m_stall < CMAX) m_stall++;
      if (exp_o[O_PCSEL] && m_flush < CMAX) m_flush++;
      if (s.mem_valid && (s.mem_read || s.mem_write) && s.dmem_resp) begin
        if (!m_ind2 && s.mem_indirect) m_ind2 = 1;
        else if (m_ind2) m_ind2 = 0;
      end
    end
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.imem_resp = 1;
    s.id_src1 = 3'd1; s.id_src2 = 3'd2; s.ex_dest = 3'd7;
    return s;
  endfunction

  task automatic do_reset();
    stim_t s = idle();
    s.rst = 1;
    step(s);
    step(s);
  endtask

  initial begin
    stim_t s;
    // Reset state and release
    do_reset();
    check("reset_outputs", int'(last_out), int'(14'b01111_1111_00000));
    step(idle());
    check("release_outputs", int'(last_out), int'(14'b11111_0000_00000));
    check("reset_stall_cnt", int'(stall_count), 0);
    check("reset_flush_cnt", int'(flush_count), 0);

    // LDR: response on third cycle
    do_reset();
    s = idle(); s.mem_valid = 1; s.mem_read = 1;
    step(s);
    check("ldr_c1_hold", int'({last_out[O_LPC], last_out[O_LEXMEM], last_out[O_BMEMWB], last_out[O_RD]}), 4'b0011);
    step(s);
    s.dmem_resp = 1;
    step(s);
    check("ldr_c3_adv", int'({last_out[O_LPC], last_out[O_LEXMEM], last_out[O_BMEMWB], last_out[O_RD]}), 4'b1101);
    step(idle());
    check("ldr_stall_cnt", int'(stall_count), 2);

    // LDI: responses on cycles 2 and 4
    do_reset();
    s = idle(); s.mem_valid = 1; s.mem_read = 1; s.mem_indirect = 1;
    step(s);
    s.dmem_resp = 1;
    step(s);
    check("ldi_latch", int'({last_out[O_LATCH], last_out[O_LPC]}), 2'b10);
    s.dmem_resp = 0;
    step(s);
    check("ldi_ind2", int'({last_out[O_AIND], last_out[O_LPC], last_out[O_RD]}), 3'b101);
    s.dmem_resp = 1;
    step(s);
    check("ldi_adv", int'({last_out[O_AIND], last_out[O_LPC]}), 2'b11);
    step(idle());
    check("ldi_stall_cnt", int'(stall_count), 3);

    // Load-use on src2, then the same without the use bit
    do_reset();
    s = idle(); s.ex_valid = 1; s.ex_is_load = 1; s.ex_dest = 3'd3;
    s.id_src2 = 3'd3; s.id_use2 = 1;
    step(s);
    check("lu_stall", int'({last_out[O_LPC], last_out[O_LIFID], last_out[O_BIDEX]}), 3'b001);
    s.id_use2 = 0;
    step(s);
    check("lu_nouse", int'({last_out[O_LPC], last_out[O_LIFID], last_out[O_BIDEX]}), 3'b110);

    // Taken branch while fetch is outstanding
    do_reset();
    s = idle(); s.mem_valid = 1; s.br_taken = 1; s.imem_resp = 0;
    step(s);
    step(s);
    check("br_freeze", int'({last_out[O_LPC], last_out[O_PCSEL], last_out[O_BMEMWB]}), 3'b001);
    s.imem_resp = 1;
    step(s);
    check("br_redirect", int'(last_out[O_LPC:O_BMEMWB] & 9'h1FF), int'(9'b11111_1110));
    check("br_pcsel", int'(last_out[O_PCSEL]), 1);
    step(idle());
    check("br_flush_cnt", int'(flush_count), 1);
    check("br_stall_cnt", int'(stall_count), 2);

    // Counter saturation
    do_reset();
    s = idle(); s.imem_resp = 0;
    for (int i = 0; i < CMAX + 6; i++) step(s);
    step(idle());
    check("stall_saturate", int'(stall_count), CMAX);

    // Random traffic
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      s = '0;
      s.rst          = ($urandom_range(0, 59) == 0);
      s.imem_resp    = ($urandom_range(0, 3) != 0);
      s.dmem_resp    = $urandom_range(0, 1) == 1;
      s.mem_valid    = ($urandom_range(0, 3) != 0);
      s.mem_read     = $urandom_range(0, 1) == 1;
      s.mem_write    = $urandom_range(0, 1) == 1;
      s.mem_indirect = ($urandom_range(0, 3) == 0);
      s.br_taken     = ($urandom_range(0, 5) == 0);
      s.ex_valid     = $urandom_range(0, 1) == 1;
      s.ex_is_load   = $urandom_range(0, 1) == 1;
      s.ex_dest      = 3'($urandom_range(0, 7));
      s.id_src1      = 3'($urandom_range(0, 7));
      s.id_src2      = 3'($urandom_range(0, 7));
      s.id_use1      = $urandom_range(0, 1) == 1;
      s.id_use2      = $urandom_range(0, 1) == 1;
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
